// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Results are held in a one-entry response register owned by the accepted requester.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int FUNC_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [FUNC_WIDTH-1:0] req0_ctrl,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [FUNC_WIDTH-1:0] req1_ctrl,

  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp0_err,

  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  rsp1_err,

  output logic [DATA_WIDTH-1:0] alu_bus_A,
  output logic [DATA_WIDTH-1:0] alu_bus_B,
  output logic [FUNC_WIDTH-1:0] alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_bus_out
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Largest function code the ALU supports; any larger code sets the error flag.
  localparam logic [FUNC_WIDTH-1:0] MAX_CTRL = FUNC_WIDTH'(15);

  state_t                state_q, state_d;
  logic                  rsp_owner_q, rsp_owner_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  last_grant_q, last_grant_d;

  logic owner_ready;
  logic can_accept;
  logic win0;
  logic win1;
  logic accept0;
  logic accept1;

  // Arbitration and ALU operand steering; the requester that did not win last gets priority.
  always_comb begin
    owner_ready = rsp_owner_q ? rsp1_ready : rsp0_ready;
    can_accept  = (state_q == EMPTY) || owner_ready;
    win0        = !rst && req0_valid && (!req1_valid || last_grant_q);
    win1        = !rst && req1_valid && (!req0_valid || !last_grant_q);
    req0_ready  = win0 && can_accept;
    req1_ready  = win1 && can_accept;
    accept0     = req0_valid && req0_ready;
    accept1     = req1_valid && req1_ready;

    alu_bus_A = '0;
    alu_bus_B = '0;
    alu_ctrl  = '0;
    if (win0) begin
      alu_bus_A = req0_a;
      alu_bus_B = req0_b;
      alu_ctrl  = req0_ctrl;
    end else if (win1) begin
      alu_bus_A = req1_a;
      alu_bus_B = req1_b;
      alu_ctrl  = req1_ctrl;
    end
  end

  always_comb begin
    state_d      = state_q;
    rsp_owner_d  = rsp_owner_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    last_grant_d = last_grant_q;

    if (accept0 || accept1) begin
      state_d      = FULL;
      rsp_owner_d  = accept1;
      rsp_data_d   = alu_bus_out;
      rsp_err_d    = (alu_ctrl > MAX_CTRL);
      last_grant_d = accept1;
    end else if ((state_q == FULL) && owner_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      rsp_owner_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      rsp_owner_q  <= rsp_owner_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Outputs are forced quiet while reset is held, even before the first reset edge.
  always_comb begin
    rsp0_valid = !rst && (state_q == FULL) && !rsp_owner_q;
    rsp1_valid = !rst && (state_q == FULL) && rsp_owner_q;
    rsp0_data  = rst ? '0 : rsp_data_q;
    rsp1_data  = rst ? '0 : rsp_data_q;
    rsp0_err   = !rst && rsp_err_q;
    rsp1_err   = !rst && rsp_err_q;
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU attached to its ALU port.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_ctrl, req1_ctrl;
  logic        rsp0_valid, rsp0_ready, rsp0_err;
  logic        rsp1_valid, rsp1_ready, rsp1_err;
  logic [31:0] rsp0_data, rsp1_data;
  logic [31:0] alu_bus_A, alu_bus_B, alu_bus_out;
  logic [4:0]  alu_ctrl;

  int checks = 0;
  int errors = 0;
  int acc_cnt1 = 0;

  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  int          grant_q[$];

  alu_share_arbiter #(.DATA_WIDTH(32), .FUNC_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .alu_bus_A(alu_bus_A), .alu_bus_B(alu_bus_B), .alu_ctrl(alu_ctrl), .alu_bus_out(alu_bus_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: code 1 computes B - A, codes above 9 produce zero.
  function automatic logic [31:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] c);
    case (c)
      5'd0:    return a + b;
      5'd1:    return b - a;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      5'd5:    return {31'd0, ($signed(a) < $signed(b))};
      5'd6:    return {31'd0, (a < b)};
      5'd7:    return a << b[4:0];
      5'd8:    return a >> b[4:0];
      5'd9:    return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_bus_out = aluModel(alu_bus_A, alu_bus_B, alu_ctrl);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [4:0] c0, input logic v1, input logic [31:0] a1,
                               input logic [31:0] b1, input logic [4:0] c1,
                               input logic r0, input logic r1);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
    rsp0_ready = r0; rsp1_ready = r1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyIdle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
  endtask

  // Monitor: pushes model results on accept, pops and compares on drain, checks one-cycle latency.
  initial begin
    logic        prev_acc0, prev_acc1, acc0, acc1;
    logic [32:0] e;
    prev_acc0 = 0;
    prev_acc1 = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q0.delete();
        exp_q1.delete();
        grant_q.delete();
        prev_acc0 = 0;
        prev_acc1 = 0;
      end else begin
        if (prev_acc0) checkOutput("latency0", {31'd0, rsp0_valid}, 1);
        if (prev_acc1) checkOutput("latency1", {31'd0, rsp1_valid}, 1);
        if (rsp0_valid && rsp0_ready) begin
          checkOutput("sb_pending0", {31'd0, exp_q0.size() > 0}, 1);
          if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            checkOutput("sb_rsp0_data", rsp0_data, e[31:0]);
            checkOutput("sb_rsp0_err", {31'd0, rsp0_err}, {31'd0, e[32]});
          end
        end
        if (rsp1_valid && rsp1_ready) begin
          checkOutput("sb_pending1", {31'd0, exp_q1.size() > 0}, 1);
          if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            checkOutput("sb_rsp1_data", rsp1_data, e[31:0]);
            checkOutput("sb_rsp1_err", {31'd0, rsp1_err}, {31'd0, e[32]});
          end
        end
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        if (acc0) begin
          exp_q0.push_back({(req0_ctrl > 5'd15), aluModel(req0_a, req0_b, req0_ctrl)});
          grant_q.push_back(0);
        end
        if (acc1) begin
          exp_q1.push_back({(req1_ctrl > 5'd15), aluModel(req1_a, req1_b, req1_ctrl)});
          grant_q.push_back(1);
          acc_cnt1++;
        end
        prev_acc0 = acc0;
        prev_acc1 = acc1;
      end
    end
  end

  initial begin
    int acc_before;
    rst = 1'b1;
    applyStimulus(1, 5, 3, 0, 1, 7, 7, 0, 1, 1);

    // Outputs stay quiet during reset even with requests pending.
    step();
    step();
    checkOutput("rst_rsp0_valid", {31'd0, rsp0_valid}, 0);
    checkOutput("rst_rsp1_valid", {31'd0, rsp1_valid}, 0);
    checkOutput("rst_req0_ready", {31'd0, req0_ready}, 0);
    checkOutput("rst_req1_ready", {31'd0, req1_ready}, 0);
    checkOutput("rst_alu_a", alu_bus_A, 0);
    checkOutput("rst_rsp0_data", rsp0_data, 0);

    // Single request from req0.
    step();
    rst = 1'b0;
    applyStimulus(1, 5, 3, 0, 0, 0, 0, 0, 1, 1);
    #1;
    checkOutput("single_alu_a", alu_bus_A, 5);
    checkOutput("single_alu_b", alu_bus_B, 3);
    checkOutput("single_req0_ready", {31'd0, req0_ready}, 1);
    step();
    applyIdle();
    #1;
    checkOutput("single_rsp0_valid", {31'd0, rsp0_valid}, 1);
    checkOutput("single_rsp0_data", rsp0_data, 8);
    checkOutput("single_rsp0_err", {31'd0, rsp0_err}, 0);
    checkOutput("single_rsp1_valid", {31'd0, rsp1_valid}, 0);
    step();
    checkOutput("single_drained", {31'd0, rsp0_valid}, 0);

    // Contention right after reset: grants alternate starting with req0.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      if (i == 0) applyStimulus(1, 2, 9, 5'd1, 1, 32'hFFFF_FFFF, 1, 5'd5, 1, 1);
      #1;
      checkOutput("cont_req0_ready", {31'd0, req0_ready}, {31'd0, (i % 2 == 0)});
      checkOutput("cont_req1_ready", {31'd0, req1_ready}, {31'd0, (i % 2 == 1)});
      if (i % 2 == 1) begin
        checkOutput("cont_rsp0_data", rsp0_data, 7);
      end else if (i > 0) begin
        checkOutput("cont_rsp1_data", rsp1_data, 1);
      end
    end
    step();
    applyIdle();
    #1;
    checkOutput("cont_rsp1_last", rsp1_data, 1);
    checkOutput("cont_grant_cnt", grant_q.size(), 4);
    for (int i = 0; i < 4 && i < grant_q.size(); i++)
      checkOutput("cont_grant_order", grant_q[i], i % 2);
    step();

    // Backpressure: owner stalls, both readies drop, held data stays stable.
    applyStimulus(1, 10, 20, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checkOutput("bp_req0_ready", {31'd0, req0_ready}, 1);
    step();
    applyStimulus(0, 0, 0, 0, 1, 3, 6, 5'd2, 0, 1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      #1;
      checkOutput("bp_req0_ready_low", {31'd0, req0_ready}, 0);
      checkOutput("bp_req1_ready_low", {31'd0, req1_ready}, 0);
      checkOutput("bp_rsp0_valid", {31'd0, rsp0_valid}, 1);
      checkOutput("bp_rsp0_data", rsp0_data, 30);
    end
    step();
    rsp0_ready = 1'b1;
    #1;
    checkOutput("bp_release_req1_ready", {31'd0, req1_ready}, 1);
    step();
    applyIdle();
    #1;
    checkOutput("bp_rsp1_valid", {31'd0, rsp1_valid}, 1);
    checkOutput("bp_rsp1_data", rsp1_data, 2);
    checkOutput("bp_rsp0_valid_low", {31'd0, rsp0_valid}, 0);

    // Back-to-back stream from req1.
    acc_before = acc_cnt1;
    for (int i = 0; i < 8; i++) begin
      step();
      applyStimulus(0, 0, 0, 0, 1, i * 3 + 1, i + 100, 5'(i % 6), 0, 1);
      #1;
      checkOutput("tput_req1_ready", {31'd0, req1_ready}, 1);
    end
    step();
    applyIdle();
    step();
    checkOutput("tput_accepts", acc_cnt1 - acc_before, 8);

    // Unsupported function code returns zero with error, next op is clean.
    applyStimulus(0, 0, 0, 0, 1, 7, 9, 5'b10101, 0, 1);
    step();
    applyStimulus(0, 0, 0, 0, 1, 1, 2, 5'd0, 0, 1);
    #1;
    checkOutput("unsup_rsp1_valid", {31'd0, rsp1_valid}, 1);
    checkOutput("unsup_rsp1_data", rsp1_data, 0);
    checkOutput("unsup_rsp1_err", {31'd0, rsp1_err}, 1);
    step();
    applyIdle();
    #1;
    checkOutput("after_unsup_data", rsp1_data, 3);
    checkOutput("after_unsup_err", {31'd0, rsp1_err}, 0);
    step();

    // Reset while a req0 result is held and stalled.
    applyStimulus(1, 4, 4, 0, 0, 0, 0, 0, 0, 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checkOutput("mid_rsp0_valid", {31'd0, rsp0_valid}, 1);
    step();
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", {31'd0, rsp0_valid}, 0);
    checkOutput("mid_rst_data", rsp0_data, 0);
    step();
    rst = 1'b0;
    applyStimulus(1, 11, 12, 5'd4, 1, 13, 14, 5'd3, 1, 1);
    #1;
    checkOutput("post_rst_valid", {31'd0, rsp0_valid}, 0);
    checkOutput("post_rst_data", rsp0_data, 0);
    checkOutput("post_rst_req0_first", {31'd0, req0_ready}, 1);
    checkOutput("post_rst_req1_wait", {31'd0, req1_ready}, 0);
    step();
    applyIdle();
    step();
    step();
    step();

    checkOutput("sb_empty0", exp_q0.size(), 0);
    checkOutput("sb_empty1", exp_q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single combinational ALU between two requesters (req0: integer execute path, req1: branch/compare path) with valid/ready handshakes on both sides. It selects one request per cycle with round-robin priority, drives the ALU operand and function inputs, and captures the ALU result into a one-entry response register. The result returns to the owning requester one cycle after acceptance, with full throughput when responses are drained every cycle.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width
- FUNC_WIDTH, 5, ALU function-code width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- reqN_valid  in  1  request pending (N = 0, 1)
- reqN_ready  out  1  request accepted this cycle when high with reqN_valid
- reqN_a  in  DATA_WIDTH  operand A
- reqN_b  in  DATA_WIDTH  operand B
- reqN_ctrl  in  FUNC_WIDTH  ALU function code
- rspN_valid  out  1  result for requester N held
- rspN_ready  in  1  requester N consumes result
- rspN_data  out  DATA_WIDTH  result
- rspN_err  out  1  function code was unsupported (> 5'b01111)
- alu_bus_A  out  DATA_WIDTH  to ALU bus_A
- alu_bus_B  out  DATA_WIDTH  to ALU bus_B
- alu_ctrl  out  FUNC_WIDTH  to ALU alu_ctrl
- alu_bus_out  in  DATA_WIDTH  from ALU bus_out

## Operation
- State: rsp_full (1b), rsp_owner (1b), rsp_data, rsp_err, last_grant (1b).
- Two states. EMPTY when rsp_full=0. FULL when rsp_full=1.
- can_accept = !rsp_full | (rsp_owner's rspN_ready).
- Arbitration is evaluated combinationally each cycle:
  - Only one valid: it wins.
  - Both valid: the requester with index != last_grant wins.
  - None valid: no grant.
- reqN_ready = win_N & can_accept. Requesters must not gate valid on ready.
- ALU inputs come from the winner's a/b/ctrl when a grant exists. With no grant they are all zero, which is ctrl 5'b00000 (ADD).
- On accept (reqN_valid & reqN_ready) at the edge:
  - rsp_data <= alu_bus_out
  - rsp_owner <= N
  - rsp_err <= (reqN_ctrl > 5'b01111)
  - rsp_full <= 1
  - last_grant <= N
- On response drain with no accept: rsp_full <= 0. Drain and accept in the same cycle: rsp_full stays 1 and the register loads the new result.
- rspN_valid = rsp_full & (rsp_owner == N). rspN_data and rspN_err are driven from the shared register for both N. Consumers qualify them with rspN_valid.
- rspN_ready from the non-owner is ignored.
- Unsupported codes still return the ALU output, which is 0, with rsp_err=1. There is no stall or trap.
- Arithmetic is performed by the ALU only. This block does no width conversion and passes operands unmodified.

## Timing
- Reset values: rsp_full=0, rsp_owner=0, rsp_data=0, rsp_err=0, last_grant=1, so req0 wins the first contention.
- Output values while rst is high: rspN_valid=0, rspN_data=0, rspN_err=0, reqN_ready=0. The ALU inputs are zero.
- Reset mid-operation discards any held result. No response is issued for it.
- Latency: accepted at edge k; rspN_valid is high from cycle k+1 until the owner's rspN_ready is sampled.
- Throughput: one accept per cycle while the owner drains every cycle.
- Backpressure: while FULL and the owner's rspN_ready=0, both reqN_ready=0. The held data, owner and err stay stable.
- last_grant is unchanged on cycles without an accept. Priority is therefore not lost when a winner is stalled.
- No starvation: under continuous contention and continuous draining, grants alternate 0,1,0,1.
- Combinational paths:
  - reqN_valid/a/b/ctrl -> alu_* outputs
  - alu_bus_out -> register only
  - rspN_ready -> reqN_ready

## Test plan
- Single request: req0 a=5, b=3, ctrl=00000 -> alu_bus_A=5 in the same cycle; rsp0_valid next cycle with data=8, err=0; rsp1_valid stays 0.
- Contention after reset: both valid every cycle; req0 SUB (a=2, b=9), req1 SLT (a=0xFFFFFFFF, b=1); both rsp_ready=1 -> grants alternate 0,1,0,1.
  - req0 returns 7.
  - req1 returns 1.
- Backpressure: hold rsp0_ready=0 for 3 cycles after a req0 accept -> both reqN_ready=0, and rsp0_data is stable for 3 cycles. When released, a pending req1 is accepted in that same cycle and rsp1_valid rises on the next cycle.
- Back-to-back throughput: req1 streams 8 ops with rsp1_ready=1 -> 8 accepts in 8 consecutive cycles, and results are in order.
- Unsupported code: req1 ctrl=5'b10101 -> rsp1_data=0, rsp1_err=1 next cycle. The following valid op returns err=0.
- Reset mid-operation: assert rst while rsp0_valid=1 with rsp0_ready=0 -> the next cycle has rsp0_valid=0 and data=0. Post-reset contention grants req0 first.
